// File: rtl/chess_position_ctrl.sv
// Chess board cursor: debounced five-way buttons move a 3x3 selection,
// with moves committed once per frame at the first blanking line.
module chess_position_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAME_LINE      = 480,
  parameter int WRAP            = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic [9:0] vcount,
  output logic [3:0] state,
  output logic       moved,
  output logic       pending
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] LINE = 10'(FRAME_LINE);

  typedef enum logic [2:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT,
    DIR_CENTER
  } dir_t;

  typedef enum logic {
    IDLE,
    ARMED
  } mode_t;

  logic [4:0]    raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    deb;
  logic [4:0]    deb_q;
  logic [4:0]    rise;
  logic [CW-1:0] cnt [5];
  logic [9:0]    vq;
  logic          commit;
  logic          req_any;
  dir_t          req_dir;
  dir_t          dir;
  mode_t         mode;
  mode_t         mode_nx;
  logic          latch;
  logic          apply;
  logic [3:0]    idx;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [1:0]    nr;
  logic [1:0]    nc;
  logic [3:0]    target;

  assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] != deb[i]) begin
          if (cnt[i] == CMAX) begin
            deb[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise    = deb & ~deb_q;
  assign req_any = |rise;
  assign commit  = (vcount == LINE) && (vq != LINE);

  always_comb begin
    req_dir = DIR_UP;
    if (rise[0])      req_dir = DIR_UP;
    else if (rise[1]) req_dir = DIR_DOWN;
    else if (rise[2]) req_dir = DIR_LEFT;
    else if (rise[3]) req_dir = DIR_RIGHT;
    else if (rise[4]) req_dir = DIR_CENTER;
  end

  always_ff @(posedge clock) begin
    if (reset) mode <= IDLE;
    else       mode <= mode_nx;
  end

  // A commit in the same cycle as a fresh request leaves it for next frame
  always_comb begin
    mode_nx = mode;
    latch   = 1'b0;
    apply   = 1'b0;
    unique case (mode)
      IDLE: begin
        if (req_any) begin
          mode_nx = ARMED;
          latch   = 1'b1;
        end
      end
      ARMED: begin
        if (commit) begin
          mode_nx = IDLE;
          apply   = 1'b1;
        end
      end
      default: mode_nx = IDLE;
    endcase
  end

  assign pending = (mode == ARMED);

  always_comb begin
    idx = state - 4'd1;
    row = (idx >= 4'd6) ? 2'd2 : (idx >= 4'd3) ? 2'd1 : 2'd0;
    col = 2'(idx - 4'(row) * 4'd3);
    nr  = row;
    nc  = col;
    unique case (dir)
      DIR_UP: begin
        if (row != 2'd0)   nr = row - 2'd1;
        else if (WRAP != 0) nr = 2'd2;
      end
      DIR_DOWN: begin
        if (row != 2'd2)   nr = row + 2'd1;
        else if (WRAP != 0) nr = 2'd0;
      end
      DIR_LEFT: begin
        if (col != 2'd0)   nc = col - 2'd1;
        else if (WRAP != 0) nc = 2'd2;
      end
      DIR_RIGHT: begin
        if (col != 2'd2)   nc = col + 2'd1;
        else if (WRAP != 0) nc = 2'd0;
      end
      default: begin
        nr = 2'd1;
        nc = 2'd1;
      end
    endcase
    target = 4'(nr) * 4'd3 + 4'(nc) + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= 4'd5;
      moved <= 1'b0;
      vq    <= '0;
      dir   <= DIR_UP;
    end else begin
      vq    <= vcount;
      moved <= 1'b0;
      if (latch) dir <= req_dir;
      if (apply) begin
        state <= target;
        moved <= (target != state);
      end
    end
  end

endmodule

// File: tb/tb_chess_position_ctrl.sv
// Scoreboard bench: stimulus pushes expected squares, monitors pop
// them on every moved pulse of a WRAP=0 and a WRAP=1 instance.
module tb_chess_position_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btns  = '0;
  logic [9:0] vcount = '0;
  logic [3:0] state0, state1;
  logic       moved0, moved1;
  logic       pending0, pending1;

  int checks = 0;
  int passed = 0;
  int q0[$];
  int q1[$];

  always #5 clock = ~clock;

  chess_position_ctrl #(
    .DEBOUNCE_CYCLES(4), .FRAME_LINE(480), .WRAP(0)
  ) u0 (
    .clock(clock), .reset(reset),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]),
    .btn_right(btns[3]), .btn_center(btns[4]),
    .vcount(vcount), .state(state0), .moved(moved0),
    .pending(pending0)
  );

  chess_position_ctrl #(
    .DEBOUNCE_CYCLES(4), .FRAME_LINE(480), .WRAP(1)
  ) u1 (
    .clock(clock), .reset(reset),
    .btn_up(btns[0]), .btn_down(btns[1]), .btn_left(btns[2]),
    .btn_right(btns[3]), .btn_center(btns[4]),
    .vcount(vcount), .state(state1), .moved(moved1),
    .pending(pending1)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  always @(negedge clock) begin
    if (moved0) begin
      if (q0.size() == 0) check("w0 unexpected move", int'(state0), -1);
      else check("w0 move", int'(state0), q0.pop_front());
    end
    if (moved1) begin
      if (q1.size() == 0) check("w1 unexpected move", int'(state1), -1);
      else check("w1 move", int'(state1), q1.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    btns = m;
    tick(8);
    btns = '0;
    tick(10);
  endtask

  task automatic frame();
    vcount = 10'd479;
    tick(1);
    vcount = 10'd480;
    tick(1);
    vcount = 10'd0;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    #1;
    check("reset state0", int'(state0), 5);
    check("reset state1", int'(state1), 5);
    check("reset pending0", int'(pending0), 0);
    check("reset pending1", int'(pending1), 0);
    check("reset moved0", int'(moved0), 0);
    tick(2);

    btns = 5'b01000;
    tick(6);
    check("latency pre", int'(pending0), 0);
    tick(1);
    check("latency hit", int'(pending0), 1);
    tick(3);
    btns = '0;
    tick(10);
    q0.push_back(6);
    q1.push_back(6);
    frame();
    check("right state0", int'(state0), 6);
    check("right pending0", int'(pending0), 0);
    check("right state1", int'(state1), 6);

    press(5'b00001);
    q0.push_back(3);
    q1.push_back(3);
    frame();
    check("up to 3", int'(state0), 3);

    press(5'b00001);
    check("edge pend", int'(pending0), 1);
    q1.push_back(9);
    frame();
    check("edge block", int'(state0), 3);
    check("edge wrap", int'(state1), 9);
    check("edge pend clr", int'(pending0), 0);

    btns = 5'b00100; tick(1);
    btns = 5'b00000; tick(1);
    btns = 5'b00100; tick(1);
    btns = 5'b00000; tick(10);
    check("glitch pend", int'(pending0), 0);
    frame();
    check("glitch state0", int'(state0), 3);
    check("glitch state1", int'(state1), 9);

    press(5'b10000);
    q0.push_back(5);
    q1.push_back(5);
    frame();
    check("center", int'(state0), 5);

    press(5'b01001);
    press(5'b00010);
    check("prio pend", int'(pending0), 1);
    q0.push_back(2);
    q1.push_back(2);
    frame();
    check("prio state", int'(state0), 2);
    frame();
    check("drop state0", int'(state0), 2);
    check("drop state1", int'(state1), 2);

    press(5'b00100);
    q0.push_back(1);
    q1.push_back(1);
    vcount = 10'd479;
    tick(1);
    vcount = 10'd480;
    tick(1);
    press(5'b01000);
    tick(80);
    check("hold state", int'(state0), 1);
    check("hold pend", int'(pending0), 1);
    q0.push_back(2);
    q1.push_back(2);
    vcount = 10'd479;
    tick(1);
    vcount = 10'd480;
    tick(1);
    vcount = 10'd0;
    tick(2);
    check("hold commit", int'(state0), 2);

    press(5'b00010);
    check("rst pend pre", int'(pending0), 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst state", int'(state0), 5);
    check("rst pend", int'(pending0), 0);
    frame();
    check("rst no move", int'(state0), 5);
    check("rst no move1", int'(state1), 5);

    tick(2);
    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
